cell_pos_reader: RTL

Read-side client for one per-cell position memory. On a start pulse it reads the particle count from address 0. It then fetches particle words 1..count and streams them out on a valid/ready interface. The block absorbs the memory's fixed 2-cycle read latency and downstream backpressure with a credit-controlled 4-entry FIFO. It sits between a cell memory and the force-evaluation / motion-update consumers.

---
 rtl/cell_pos_reader_if.sv | 32 +++
 rtl/cell_pos_reader.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cell_pos_reader_if.sv
// Signal bundle between the cell position reader, its cell memory and the stream consumer.
// The master modport is the reader; the slave modport is everything around it.
interface cell_pos_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] particle_count;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_pid;

  modport master (
    input  start, mem_q, out_ready,
    output busy, done, particle_count, mem_address, mem_rden, mem_wren,
           mem_data, out_valid, out_data, out_pid
  );

  modport slave (
    output start, mem_q, out_ready,
    input  busy, done, particle_count, mem_address, mem_rden, mem_wren,
           mem_data, out_valid, out_data, out_pid
  );
endinterface

// File: rtl/cell_pos_reader.sv
// Reads the particle count and then particle words 1..count from one cell memory,
// hiding the 2-cycle read latency and stream backpressure behind a credit-limited 4-deep FIFO.
module cell_pos_reader #(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220
) (
  input  logic              clk,
  input  logic              rst,
  cell_pos_reader_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, CNT_REQ, CNT_WAIT, STREAM, DRAIN} state_t;

  state_t                state, state_nx;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  cnt_latch;
  logic [ADDR_WIDTH-1:0] cnt_clamped;
  logic                  done_c;

  logic                  vld_p1, vld_p2;
  logic [ADDR_WIDTH-1:0] pid_p1, pid_p2;

  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [ADDR_WIDTH-1:0] fifo_pid  [4];
  logic [1:0]            wr_ptr, rd_ptr;
  logic [2:0]            fifo_count;
  logic                  fifo_nonempty;
  logic                  push, pop;
  logic [2:0]            in_flight;
  logic [3:0]            occupancy;
  logic                  credit_ok;

  function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
    return (raw > MAX_COUNT) ? MAX_COUNT : raw;
  endfunction

  assign cnt_clamped   = clamp_count(bus.mem_q[ADDR_WIDTH-1:0]);
  assign fifo_nonempty = (fifo_count != 3'd0);
  // pid 0 is the count word; it never enters the FIFO
  assign push          = vld_p2 && (pid_p2 != '0);
  assign pop           = fifo_nonempty && bus.out_ready;
  assign in_flight     = {2'b0, bus.mem_rden} + {2'b0, vld_p1} + {2'b0, vld_p2};
  // A pop this cycle frees its slot in time for a read issued now; this keeps 1 word/cycle.
  assign occupancy     = {1'b0, fifo_count} + {1'b0, in_flight} - {3'b0, pop};
  assign credit_ok     = (occupancy < 4'd4);

  always_comb begin
    state_nx   = state;
    issue      = 1'b0;
    issue_addr = next_addr;
    cnt_latch  = 1'b0;
    done_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          issue      = 1'b1;
          issue_addr = '0;
          state_nx   = CNT_REQ;
        end
      end
      CNT_REQ: state_nx = CNT_WAIT;
      CNT_WAIT: begin
        if (vld_p2) begin
          cnt_latch = 1'b1;
          if (cnt_clamped == '0) begin
            state_nx = DRAIN;
          end else begin
            issue      = 1'b1;
            issue_addr = ONE;
            state_nx   = (cnt_clamped == ONE) ? DRAIN : STREAM;
          end
        end
      end
      STREAM: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (next_addr == bus.particle_count) state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (in_flight == 3'd0 && fifo_count == 3'd0) begin
          done_c   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: read issue registers; p1/p2: read-latency tracking; FIFO control
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      bus.mem_rden       <= 1'b0;
      bus.mem_address    <= '0;
      bus.particle_count <= '0;
      next_addr          <= '0;
      vld_p1             <= 1'b0;
      vld_p2             <= 1'b0;
      wr_ptr             <= 2'd0;
      rd_ptr             <= 2'd0;
      fifo_count         <= 3'd0;
    end else begin
      state        <= state_nx;
      bus.mem_rden <= issue;
      if (issue) begin
        bus.mem_address <= issue_addr;
        next_addr       <= issue_addr + ONE;
      end
      if (cnt_latch) bus.particle_count <= cnt_clamped;
      vld_p1 <= bus.mem_rden;
      vld_p2 <= vld_p1;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      fifo_count <= fifo_count + {2'b0, push} - {2'b0, pop};
    end
  end

  // p1/p2 pid pipe and FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    pid_p1 <= bus.mem_address;
    pid_p2 <= pid_p1;
    if (push) begin
      fifo_data[wr_ptr] <= bus.mem_q;
      fifo_pid[wr_ptr]  <= pid_p2;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_c;
  assign bus.mem_wren  = 1'b0;
  assign bus.mem_data  = '0;
  assign bus.out_valid = fifo_nonempty;
  assign bus.out_data  = fifo_nonempty ? fifo_data[rd_ptr] : '0;
  assign bus.out_pid   = fifo_nonempty ? fifo_pid[rd_ptr]  : '0;
endmodule
